// File: rtl/red_pkg.sv
// Shared types and constants for the reduced RISC-V execute pipeline.
package red_pkg;

   // Operation codes as presented on ALUctrl.
   typedef enum logic [2:0] {
      ADD = 3'd0,
      SUB = 3'd1,
      AND = 3'd2,
      OR  = 3'd3,
      XOR = 3'd4,
      SLT = 3'd5,
      SLL = 3'd6,
      MUL = 3'd7
   } alu_op_t;

   // Occupancy of the EX stage.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2
   } ex_state_t;

   // Index of register a0, exported on the a0 port.
   localparam int A0_IDX = 10;

endpackage

// File: rtl/red_alu.sv
// Combinational ALU for all single-cycle operations plus the operand equality flag.
// MUL is produced by the iterative sequencer in the top; here it yields zero.
module red_alu
   import red_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] i_op1,
   input  logic [DATA_WIDTH-1:0] i_op2,
   input  alu_op_t               i_ctrl,
   output logic [DATA_WIDTH-1:0] o_res,
   output logic                  o_eq
);

   localparam int SH_W = $clog2(DATA_WIDTH);

   // Select the single-cycle result and compare the operands.
   always_comb begin
      o_res = '0;
      case (i_ctrl)
         ADD:     o_res = i_op1 + i_op2;
         SUB:     o_res = i_op1 - i_op2;
         AND:     o_res = i_op1 & i_op2;
         OR:      o_res = i_op1 | i_op2;
         XOR:     o_res = i_op1 ^ i_op2;
         SLT:     o_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
         SLL:     o_res = i_op1 << i_op2[SH_W-1:0];
         default: o_res = '0;
      endcase
      o_eq = (i_op1 == i_op2);
   end

endmodule

// File: rtl/red_exec_pipe.sv
// Two-stage execute datapath: register file, issue with EX bypass, registered
// EX stage with an iterative shift-add multiplier, and a registered result port.
module red_exec_pipe
   import red_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5,
   parameter int ALUctrl_WIDTH = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDRESS_WIDTH-1:0] rs1,
   input  logic [ADDRESS_WIDTH-1:0] rs2,
   input  logic [ADDRESS_WIDTH-1:0] rd,
   input  logic                     RegWrite,
   input  logic                     ALUsrc,
   input  logic [ALUctrl_WIDTH-1:0] ALUctrl,
   input  logic [DATA_WIDTH-1:0]    ImmOp,
   output logic                     res_valid,
   output logic [DATA_WIDTH-1:0]    res_data,
   output logic [ADDRESS_WIDTH-1:0] res_rd,
   output logic                     EQ,
   output logic [DATA_WIDTH-1:0]    a0
);

   localparam int                   CNT_W    = $clog2(DATA_WIDTH);
   localparam int                   NREGS    = 1 << ADDRESS_WIDTH;
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [ADDRESS_WIDTH-1:0] A0_ADDR = ADDRESS_WIDTH'(A0_IDX);

   // Architectural state
   logic [DATA_WIDTH-1:0]    r_regs [NREGS];

   // EX stage (ID/EX register) and multiplier sequencer
   ex_state_t                r_state;
   logic [CNT_W-1:0]         r_cnt;
   logic [DATA_WIDTH-1:0]    r_op1;
   logic [DATA_WIDTH-1:0]    r_op2;
   logic [ADDRESS_WIDTH-1:0] r_rd;
   logic                     r_regwrite;
   alu_op_t                  r_aluctrl;
   logic [DATA_WIDTH-1:0]    r_mcand;
   logic [DATA_WIDTH-1:0]    r_mplier;
   logic [DATA_WIDTH-1:0]    r_acc;

   // Combinational nets
   logic                     w_mul_last;
   logic                     w_ex_last;
   logic                     w_ready;
   logic                     w_accept;
   logic                     w_bypass_ok;
   logic                     w_wb_en;
   alu_op_t                  w_new_op;
   logic [DATA_WIDTH-1:0]    w_alu_res;
   logic                     w_alu_eq;
   logic [DATA_WIDTH-1:0]    w_mul_step;
   logic [DATA_WIDTH-1:0]    w_ex_res;
   logic [DATA_WIDTH-1:0]    w_op1;
   logic [DATA_WIDTH-1:0]    w_op2;

   red_alu #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_alu (
      .i_op1  (r_op1),
      .i_op2  (r_op2),
      .i_ctrl (r_aluctrl),
      .o_res  (w_alu_res),
      .o_eq   (w_alu_eq)
   );

   // Stage control: an op finishes EX this cycle in EXEC or in the last MUL step;
   // issue stalls only while a multiply still has steps left.
   always_comb begin
      w_mul_last  = (r_state == ST_MUL) && (r_cnt == CNT_LAST);
      w_ex_last   = (r_state == ST_EXEC) || w_mul_last;
      w_ready     = !((r_state == ST_MUL) && (r_cnt != CNT_LAST));
      w_accept    = in_valid && w_ready;
      w_bypass_ok = w_ex_last && r_regwrite && (r_rd != '0);
      w_wb_en     = w_ex_last && r_regwrite && (r_rd != '0);
      w_new_op    = alu_op_t'(ALUctrl[2:0]);
   end

   // One shift-add step; in the final step this is the finished product.
   always_comb begin
      if (r_mplier[0]) begin
         w_mul_step = r_acc + r_mcand;
      end else begin
         w_mul_step = r_acc;
      end
   end

   // Result leaving EX this cycle.
   always_comb begin
      if (r_state == ST_MUL) begin
         w_ex_res = w_mul_step;
      end else begin
         w_ex_res = w_alu_res;
      end
   end

   // Operand resolution: x0 reads zero, EX result overrides the register file.
   always_comb begin
      if (w_bypass_ok && (r_rd == rs1)) begin
         w_op1 = w_ex_res;
      end else if (rs1 == '0) begin
         w_op1 = '0;
      end else begin
         w_op1 = r_regs[rs1];
      end

      if (ALUsrc) begin
         w_op2 = ImmOp;
      end else if (w_bypass_ok && (r_rd == rs2)) begin
         w_op2 = w_ex_res;
      end else if (rs2 == '0) begin
         w_op2 = '0;
      end else begin
         w_op2 = r_regs[rs2];
      end
   end

   // EX state machine: issue into the ID/EX register or advance the multiplier.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_op1      <= '0;
         r_op2      <= '0;
         r_rd       <= '0;
         r_regwrite <= 1'b0;
         r_aluctrl  <= ADD;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_acc      <= '0;
      end else if (w_ready) begin
         if (w_accept) begin
            r_op1      <= w_op1;
            r_op2      <= w_op2;
            r_rd       <= rd;
            r_regwrite <= RegWrite;
            r_aluctrl  <= w_new_op;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mcand    <= w_op1;
            r_mplier   <= w_op2;
            if (w_new_op == MUL) begin
               r_state <= ST_MUL;
            end else begin
               r_state <= ST_EXEC;
            end
         end else begin
            r_state <= ST_IDLE;
         end
      end else begin
         r_state  <= ST_MUL;
         r_cnt    <= r_cnt + CNT_W'(1);
         r_acc    <= w_mul_step;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
      end
   end

   // Register file write at the end of an op's last EX cycle; x0 is never written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wb_en) begin
         r_regs[r_rd] <= w_ex_res;
      end else begin
         r_regs[0] <= '0;
      end
   end

   // Registered retire port: one-cycle valid pulse with data, rd and EQ.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_rd    <= '0;
         EQ        <= 1'b0;
      end else begin
         res_valid <= w_ex_last;
         if (w_ex_last) begin
            res_data <= w_ex_res;
            res_rd   <= r_rd;
            EQ       <= w_alu_eq;
         end else begin
            res_data <= res_data;
            res_rd   <= res_rd;
            EQ       <= EQ;
         end
      end
   end

   assign in_ready = w_ready;
   assign a0       = r_regs[A0_ADDR];

endmodule

// File: doc/red_exec_pipe.md
# red_exec_pipe

Parametrised two-stage execute datapath succeeding the single-cycle register-file-plus-ALU top of the reduced RISC-V CPU. Holds the architectural register file. Accepts one decoded operation per cycle through a valid/ready handshake, reads operands with EX→issue bypass, executes in a registered EX stage, and writes back at the end of EX. Adds an iterative multiply that stalls issue, a registered result/EQ port, and asynchronous reset of all state.

## Interface
- `DATA_WIDTH`, 32: register and ALU width; must be ≥ 8 and a power of two.
- `ADDRESS_WIDTH`, 5: register index width; must be ≥ 4, since register 10 (a0) must exist.
- `ALUctrl_WIDTH`, 3: width of the operation code.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: an operation is presented.
- `in_ready`  out  1: the operation is accepted this cycle when `in_valid` is also high.
- `rs1`, `rs2`, `rd`  in  ADDRESS_WIDTH: source and destination indices.
- `RegWrite`  in  1: write the result to `rd`.
- `ALUsrc`  in  1: when 1, op2 is `ImmOp`; when 0, op2 is the `rs2` value.
- `ALUctrl`  in  ALUctrl_WIDTH: operation code.
- `ImmOp`  in  DATA_WIDTH: immediate.
- `res_valid`  out  1: one-cycle pulse; a result has retired.
- `res_data`  out  DATA_WIDTH: retired result.
- `res_rd`  out  ADDRESS_WIDTH: retired destination index.
- `EQ`  out  1: for the retired operation, op1 == op2.
- `a0`  out  DATA_WIDTH: current contents of register 10.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 MUL.
- SLT is a signed compare; the result is zero-extended 0 or 1.
- SLL shifts by `op2[$clog2(DATA_WIDTH)-1:0]`.
- ADD, SUB and MUL wrap modulo 2^DATA_WIDTH; MUL returns the low DATA_WIDTH bits.
- Register 0 reads as 0. Writes to rd = 0 are dropped, but the operation still retires with `res_rd` = 0 and its computed `res_data`.
- Issue: on accept, op1 and op2 are resolved and latched into the ID/EX register together with rd, RegWrite and ALUctrl.
- Bypass: if EX holds a valid operation with RegWrite = 1, rd ≠ 0 and rd equal to rs1 or rs2, the issue stage uses the EX result this cycle instead of the register file.
- Bypass for MUL is taken only in MUL's final cycle, because issue is stalled otherwise.
- EX state machine:
  - IDLE: EX is empty.
  - EXEC: single-cycle operation.
  - MUL: shift-add multiply with a counter over 0..DATA_WIDTH-1, one bit per cycle.
- Transitions:
  - IDLE or EXEC → EXEC on accept of a non-MUL op.
  - IDLE or EXEC → MUL on accept of MUL.
  - IDLE or EXEC → IDLE with no accept.
  - MUL → MUL while the counter ≠ DATA_WIDTH-1.
  - At counter = DATA_WIDTH-1, MUL behaves as EXEC for the accept decision.
- Writeback happens at the rising edge that ends an op's last EX cycle: register write when RegWrite = 1 and rd ≠ 0, plus registered `res_valid` = 1, `res_data`, `res_rd`, `EQ`.
- `in_ready` = 0 only while in MUL with counter < DATA_WIDTH-1; otherwise 1.
- `in_ready` does not depend on `in_valid`.
- There is no backpressure on the result port.

## Timing
- Reset values: all registers 0; `res_valid` = 0, `res_data` = 0, `res_rd` = 0, `EQ` = 0, `a0` = 0; state IDLE; counter 0.
- Reset asserted mid-MUL aborts the multiply with no writeback.
- Non-MUL latency: accept at edge t, writeback and `res_valid` at edge t+1 (two edges after the cycle the op was presented).
- MUL latency: accept at edge t, `res_valid` at edge t+DATA_WIDTH. Issue is blocked for DATA_WIDTH-1 cycles.
- Throughput: one non-MUL op per cycle.
- `a0` reflects register 10 after writeback. It updates the cycle after the write edge and is not bypassed.
- Back-to-back dependent ops need zero bubbles.
- A read of the same register written two or more ops earlier comes from the register file.
- No accept while `rst_n` = 0.

## Structure
- Package `red_pkg`:
  - `alu_op_t` enum: ADD, SUB, AND, OR, XOR, SLT, SLL, MUL.
  - `ex_state_t` enum: IDLE, EXEC, MUL.
  - Constant `A0_IDX` = 10.
- Sub-module `red_alu`: purely combinational, covering the single-cycle ops and EQ.
- The multiplier sequencer, register file and bypass logic stay in `red_exec_pipe`.

## Test plan
- Reset, then ADD x1 = x0 + imm 5 (ALUsrc = 1) → `res_valid` two edges later; `res_data` = 5, `res_rd` = 1, `EQ` = 0.
- Back-to-back: x1 = x0 + 7, x2 = x1 + x1, x10 = x2 − x1, each ALUsrc = 0 for the register ops → results 7, 14, 7; `a0` = 7; no bubbles.
- MUL with x3 = 0xFFFF_FFFF and x4 = 3 → result 0xFFFF_FFFD after 32 edges; `in_ready` low for 31 cycles.
- MUL followed by a dependent ADD using the MUL's rd → the ADD is accepted in MUL's final cycle with the bypassed product.
- Writes to x0, then a read of x0 → reads 0, with `res_rd` = 0 still reported.
- Reset asserted mid-MUL, then an ADD x5 = x0 + 1 → no MUL result, `a0` = 0, and the ADD returns 1.
- SLT −1 < 1 → 1.
- SLL by 33 with DATA_WIDTH = 32 → shift amount 1.
- SUB equal operands → 0 with `EQ` = 1.
